// File: rtl/mips32_mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS32 control unit: state encodings,
// datapath select constants and the existing opcode/function/ALU codes.
package mips32_mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_MEM = 3'd1,
    CLS_IMM = 3'd2,
    CLS_BR  = 3'd3,
    CLS_J   = 3'd4,
    CLS_BAD = 3'd5
  } instr_class_t;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] WDSEL_ALUOUT = 2'd0;
  localparam logic [1:0] WDSEL_MDR    = 2'd1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/mips32_mc_control_if.sv
// Control bus between the instruction register / datapath and the control FSM.
// master = control unit side, slave = datapath side.
interface mips32_mc_control_if;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       memReady;
  logic       pcWrite;
  logic       irWrite;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       rfWriteEnable;
  logic       rfWriteAddrSel;
  logic [1:0] rfWriteDataSel;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluFunc;
  logic       bitXtend;
  logic [1:0] pcSrc;
  logic       isBeq;
  logic       isBne;
  logic       invOpcode;

  modport master (
    input  opc, func, zero, memReady,
    output pcWrite, irWrite, iorD, memRead, memWrite, rfWriteEnable, rfWriteAddrSel,
           rfWriteDataSel, aluSrcA, aluSrcB, aluFunc, bitXtend, pcSrc, isBeq, isBne,
           invOpcode
  );

  modport slave (
    output opc, func, zero, memReady,
    input  pcWrite, irWrite, iorD, memRead, memWrite, rfWriteEnable, rfWriteAddrSel,
           rfWriteDataSel, aluSrcA, aluSrcB, aluFunc, bitXtend, pcSrc, isBeq, isBne,
           invOpcode
  );
endinterface

// File: rtl/mips32_alu_decode.sv
// Combinational opcode/function decode: instruction class for the DECODE
// dispatch and the ALU operation used by the EXEC states.
module mips32_alu_decode
  import mips32_mc_control_pkg::*;
(
  input  logic [5:0]   opc,
  input  logic [5:0]   func,
  output logic [2:0]   aluFunc,
  output instr_class_t instrClass
);

  always_comb begin
    aluFunc    = ALU_ADD;
    instrClass = CLS_BAD;
    case (opc)
      OP_RTYPE: begin
        instrClass = CLS_R;
        case (func)
          FN_ADD:  aluFunc = ALU_ADD;
          FN_SUB:  aluFunc = ALU_SUB;
          FN_AND:  aluFunc = ALU_AND;
          FN_OR:   aluFunc = ALU_OR;
          FN_SLT:  aluFunc = ALU_SLT;
          default: instrClass = CLS_BAD;
        endcase
      end
      OP_LW, OP_SW:   instrClass = CLS_MEM;
      OP_ADDI:        instrClass = CLS_IMM;
      OP_ANDI: begin
        instrClass = CLS_IMM;
        aluFunc    = ALU_AND;
      end
      OP_ORI: begin
        instrClass = CLS_IMM;
        aluFunc    = ALU_OR;
      end
      OP_BEQ, OP_BNE: instrClass = CLS_BR;
      OP_J:           instrClass = CLS_J;
      default:        instrClass = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/mips32_mc_control.sv
// Multi-cycle MIPS32 control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back, driving the shared datapath's enables and muxes.
module mips32_mc_control
  import mips32_mc_control_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit TRAP_STICKY   = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mips32_mc_control_if.master  bus,
  output logic [STATE_W-1:0]   state
);

  state_t       stateQ;
  instr_class_t decClass;
  logic [2:0]   decAluFunc;
  logic [2:0]   aluFuncQ;
  logic         isLoadQ;
  logic         isBneQ;
  logic         memDone;

  logic       pcWrite, irWrite, iorD, memRead, memWrite;
  logic       rfWriteEnable, rfWriteAddrSel, aluSrcA, bitXtend;
  logic       isBeq, isBne, invOpcode;
  logic [1:0] rfWriteDataSel, aluSrcB, pcSrc;
  logic [2:0] aluFunc;

  mips32_alu_decode uAluDecode (
    .opc        (bus.opc),
    .func       (bus.func),
    .aluFunc    (decAluFunc),
    .instrClass (decClass)
  );

  assign memDone = USE_MEM_READY ? bus.memReady : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ <= S_FETCH;
    end else begin
      case (stateQ)
        S_FETCH:    if (memDone) stateQ <= S_DECODE;
        S_DECODE: begin
          case (decClass)
            CLS_R:   stateQ <= S_EXEC_R;
            CLS_MEM: stateQ <= S_MEM_ADDR;
            CLS_IMM: stateQ <= S_EXEC_I;
            CLS_BR:  stateQ <= S_BRANCH;
            CLS_J:   stateQ <= S_JUMP;
            default: stateQ <= S_TRAP;
          endcase
        end
        S_EXEC_R:   stateQ <= S_WB_R;
        S_EXEC_I:   stateQ <= S_WB_I;
        S_MEM_ADDR: stateQ <= isLoadQ ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (memDone) stateQ <= S_MEM_WB;
        S_MEM_WR:   if (memDone) stateQ <= S_FETCH;
        S_TRAP:     if (!TRAP_STICKY) stateQ <= S_FETCH;
        default:    stateQ <= S_FETCH;
      endcase
    end
    // opc/func are only looked at in DECODE/EXEC; later states use these copies
    if (stateQ == S_DECODE) begin
      isLoadQ <= (bus.opc == OP_LW);
      isBneQ  <= (bus.opc == OP_BNE);
    end
    if (stateQ == S_EXEC_R || stateQ == S_EXEC_I) aluFuncQ <= decAluFunc;
  end

  always_comb begin
    pcWrite        = 1'b0;
    irWrite        = 1'b0;
    iorD           = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    rfWriteEnable  = 1'b0;
    rfWriteAddrSel = 1'b0;
    rfWriteDataSel = WDSEL_ALUOUT;
    aluSrcA        = 1'b0;
    aluSrcB        = SRCB_RT;
    aluFunc        = ALU_ADD;
    bitXtend       = 1'b0;
    pcSrc          = PCSRC_ALU;
    isBeq          = 1'b0;
    isBne          = 1'b0;
    invOpcode      = 1'b0;
    // While reset is held every strobe stays idle, so nothing aborted can write
    if (rst) begin
      case (stateQ)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = SRCB_FOUR;
          irWrite = memDone;
          pcWrite = memDone;
        end
        S_DECODE:   aluSrcB = SRCB_IMM_SH2;
        S_EXEC_R: begin
          aluSrcA = 1'b1;
          aluFunc = decAluFunc;
        end
        S_WB_R: begin
          rfWriteEnable  = 1'b1;
          rfWriteAddrSel = 1'b1;
          aluFunc        = aluFuncQ;
        end
        S_EXEC_I: begin
          aluSrcA  = 1'b1;
          aluSrcB  = SRCB_IMM;
          aluFunc  = decAluFunc;
          bitXtend = (bus.opc == OP_ANDI) || (bus.opc == OP_ORI);
        end
        S_WB_I: begin
          rfWriteEnable = 1'b1;
          aluFunc       = aluFuncQ;
        end
        S_MEM_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
        end
        S_MEM_RD: begin
          memRead = 1'b1;
          iorD    = 1'b1;
        end
        S_MEM_WB: begin
          rfWriteEnable  = 1'b1;
          rfWriteDataSel = WDSEL_MDR;
        end
        S_MEM_WR: begin
          memWrite = 1'b1;
          iorD     = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA = 1'b1;
          aluFunc = ALU_SUB;
          pcSrc   = PCSRC_ALUOUT;
          isBeq   = !isBneQ;
          isBne   = isBneQ;
          pcWrite = isBneQ ? !bus.zero : bus.zero;
        end
        S_JUMP: begin
          pcSrc   = PCSRC_JUMP;
          pcWrite = 1'b1;
        end
        S_TRAP:     invOpcode = 1'b1;
        default:    ;
      endcase
    end
  end

  assign bus.pcWrite        = pcWrite;
  assign bus.irWrite        = irWrite;
  assign bus.iorD           = iorD;
  assign bus.memRead        = memRead;
  assign bus.memWrite       = memWrite;
  assign bus.rfWriteEnable  = rfWriteEnable;
  assign bus.rfWriteAddrSel = rfWriteAddrSel;
  assign bus.rfWriteDataSel = rfWriteDataSel;
  assign bus.aluSrcA        = aluSrcA;
  assign bus.aluSrcB        = aluSrcB;
  assign bus.aluFunc        = aluFunc;
  assign bus.bitXtend       = bitXtend;
  assign bus.pcSrc          = pcSrc;
  assign bus.isBeq          = isBeq;
  assign bus.isBne          = isBne;
  assign bus.invOpcode      = invOpcode;
  assign state              = STATE_W'(stateQ);

endmodule

// File: tb/tb_mips32_mc_control.sv
// Scoreboard bench for mips32_mc_control: directed instruction sequences push
// per-cycle expected state/controls; a negedge monitor pops and compares.
module tb_mips32_mc_control;
  import mips32_mc_control_pkg::*;

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       rfWriteEnable;
    logic       rfWriteAddrSel;
    logic [1:0] rfWriteDataSel;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluFunc;
    logic       bitXtend;
    logic [1:0] pcSrc;
    logic       isBeq;
    logic       isBne;
    logic       invOpcode;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips32_mc_control_if bus1 ();
  mips32_mc_control_if bus2 ();
  logic [3:0] state1, state2;

  mips32_mc_control #(.USE_MEM_READY(1'b1), .TRAP_STICKY(1'b1), .STATE_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state(state1)
  );

  // Second instance: no memReady wait, one-cycle trap
  mips32_mc_control #(.USE_MEM_READY(1'b0), .TRAP_STICKY(1'b0), .STATE_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .state(state2)
  );

  assign bus2.opc      = bus1.opc;
  assign bus2.func     = bus1.func;
  assign bus2.zero     = bus1.zero;
  assign bus2.memReady = bus1.memReady;

  ctl_t act1, act2;
  assign act1 = {bus1.pcWrite, bus1.irWrite, bus1.iorD, bus1.memRead, bus1.memWrite,
                 bus1.rfWriteEnable, bus1.rfWriteAddrSel, bus1.rfWriteDataSel, bus1.aluSrcA,
                 bus1.aluSrcB, bus1.aluFunc, bus1.bitXtend, bus1.pcSrc, bus1.isBeq,
                 bus1.isBne, bus1.invOpcode};
  assign act2 = {bus2.pcWrite, bus2.irWrite, bus2.iorD, bus2.memRead, bus2.memWrite,
                 bus2.rfWriteEnable, bus2.rfWriteAddrSel, bus2.rfWriteDataSel, bus2.aluSrcA,
                 bus2.aluSrcB, bus2.aluFunc, bus2.bitXtend, bus2.pcSrc, bus2.isBeq,
                 bus2.isBne, bus2.invOpcode};

  exp_t  q1[$], q2[$];
  string n1[$], n2[$];
  int    total  = 0;
  int    passed = 0;

  // Hand-written expected control words
  function automatic ctl_t cIdle();
    ctl_t c = '0;
    c.aluFunc = ALU_ADD;
    return c;
  endfunction
  function automatic ctl_t cFetch(input logic rdy);
    ctl_t c = cIdle();
    c.memRead = 1'b1; c.aluSrcB = 2'd1; c.pcWrite = rdy; c.irWrite = rdy;
    return c;
  endfunction
  function automatic ctl_t cDecode();
    ctl_t c = cIdle();
    c.aluSrcB = 2'd3;
    return c;
  endfunction
  function automatic ctl_t cExecR(input logic [2:0] f);
    ctl_t c = cIdle();
    c.aluSrcA = 1'b1; c.aluSrcB = 2'd0; c.aluFunc = f;
    return c;
  endfunction
  function automatic ctl_t cWbR(input logic [2:0] f);
    ctl_t c = cIdle();
    c.rfWriteEnable = 1'b1; c.rfWriteAddrSel = 1'b1; c.aluFunc = f;
    return c;
  endfunction
  function automatic ctl_t cExecI(input logic [2:0] f, input logic bx);
    ctl_t c = cIdle();
    c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluFunc = f; c.bitXtend = bx;
    return c;
  endfunction
  function automatic ctl_t cWbI(input logic [2:0] f);
    ctl_t c = cIdle();
    c.rfWriteEnable = 1'b1; c.aluFunc = f;
    return c;
  endfunction
  function automatic ctl_t cMemAddr();
    ctl_t c = cIdle();
    c.aluSrcA = 1'b1; c.aluSrcB = 2'd2;
    return c;
  endfunction
  function automatic ctl_t cMemRd();
    ctl_t c = cIdle();
    c.memRead = 1'b1; c.iorD = 1'b1;
    return c;
  endfunction
  function automatic ctl_t cMemWb();
    ctl_t c = cIdle();
    c.rfWriteEnable = 1'b1; c.rfWriteDataSel = 2'd1;
    return c;
  endfunction
  function automatic ctl_t cMemWr();
    ctl_t c = cIdle();
    c.memWrite = 1'b1; c.iorD = 1'b1;
    return c;
  endfunction
  function automatic ctl_t cBranch(input logic bne, input logic pw);
    ctl_t c = cIdle();
    c.aluSrcA = 1'b1; c.aluSrcB = 2'd0; c.aluFunc = ALU_SUB; c.pcSrc = 2'd1;
    c.isBeq = !bne; c.isBne = bne; c.pcWrite = pw;
    return c;
  endfunction
  function automatic ctl_t cJump();
    ctl_t c = cIdle();
    c.pcSrc = 2'd2; c.pcWrite = 1'b1;
    return c;
  endfunction
  function automatic ctl_t cTrap();
    ctl_t c = cIdle();
    c.invOpcode = 1'b1;
    return c;
  endfunction

  task automatic check(input string nm, input exp_t got, input exp_t want);
    total++;
    if (got !== want)
      $display("FAIL %s: got state=%0d ctl=%06h, want state=%0d ctl=%06h",
               nm, got.st, got.c, want.st, want.c);
    else
      passed++;
  endtask

  exp_t  e1, e2;
  string s1, s2;
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      s1 = n1.pop_front();
      check(s1, {state1, act1}, e1);
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      s2 = n2.pop_front();
      check(s2, {state2, act2}, e2);
    end
  end

  task automatic step(input string nm, input logic [3:0] st, input ctl_t c);
    q1.push_back({st, c});
    n1.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input string nm, input logic [3:0] st, input ctl_t c,
                       input logic [3:0] stB, input ctl_t cB);
    q2.push_back({stB, cB});
    n2.push_back({nm, "_u2"});
    step(nm, st, c);
  endtask

  task automatic resetDut();
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("rst_idle", S_FETCH, cIdle());
    rst = 1'b1;
  endtask

  initial begin
    bus1.opc = 6'h3F; bus1.func = 6'h00; bus1.zero = 1'b0; bus1.memReady = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step2("rst0", S_FETCH, cIdle(), S_FETCH, cIdle());
    rst = 1'b1;

    // Illegal opcode: dut1 waits on memReady and traps forever, dut2 traps once
    step2("trap_fetch_stall", S_FETCH, cFetch(1'b0), S_FETCH, cFetch(1'b1));
    bus1.memReady = 1'b1;
    step2("trap_fetch", S_FETCH, cFetch(1'b1), S_DECODE, cDecode());
    step2("trap_decode", S_DECODE, cDecode(), S_TRAP, cTrap());
    step2("trap_enter", S_TRAP, cTrap(), S_FETCH, cFetch(1'b1));
    bus1.opc = OP_ADDI;
    for (int i = 0; i < 9; i++) step("trap_hold", S_TRAP, cTrap());
    resetDut();

    // AND; func changes during WB_R must not alter the latched ALU op
    bus1.opc = OP_RTYPE; bus1.func = FN_AND;
    step("and_fetch", S_FETCH, cFetch(1'b1));
    step("and_decode", S_DECODE, cDecode());
    step("and_exec", S_EXEC_R, cExecR(ALU_AND));
    bus1.func = FN_SUB;
    step("and_wb", S_WB_R, cWbR(ALU_AND));

    // LW with two memReady stalls in MEM_RD; opc changes after DECODE
    bus1.opc = OP_LW;
    step("lw_fetch", S_FETCH, cFetch(1'b1));
    step("lw_decode", S_DECODE, cDecode());
    bus1.opc = OP_SW;
    step("lw_addr", S_MEM_ADDR, cMemAddr());
    bus1.memReady = 1'b0;
    step("lw_rd_wait1", S_MEM_RD, cMemRd());
    step("lw_rd_wait2", S_MEM_RD, cMemRd());
    bus1.memReady = 1'b1;
    step("lw_rd_done", S_MEM_RD, cMemRd());
    step("lw_wb", S_MEM_WB, cMemWb());

    // BNE not taken-zero, then BNE with zero set, then BEQ taken
    bus1.opc = OP_BNE; bus1.zero = 1'b0;
    step("bne0_fetch", S_FETCH, cFetch(1'b1));
    step("bne0_decode", S_DECODE, cDecode());
    step("bne0_branch", S_BRANCH, cBranch(1'b1, 1'b1));
    bus1.zero = 1'b1;
    step("bne1_fetch", S_FETCH, cFetch(1'b1));
    step("bne1_decode", S_DECODE, cDecode());
    step("bne1_branch", S_BRANCH, cBranch(1'b1, 1'b0));
    bus1.opc = OP_BEQ;
    step("beq1_fetch", S_FETCH, cFetch(1'b1));
    step("beq1_decode", S_DECODE, cDecode());
    step("beq1_branch", S_BRANCH, cBranch(1'b0, 1'b1));
    bus1.zero = 1'b0;

    // ORI (zero extend) and ADDI (sign extend)
    bus1.opc = OP_ORI;
    step("ori_fetch", S_FETCH, cFetch(1'b1));
    step("ori_decode", S_DECODE, cDecode());
    step("ori_exec", S_EXEC_I, cExecI(ALU_OR, 1'b1));
    step("ori_wb", S_WB_I, cWbI(ALU_OR));
    bus1.opc = OP_ADDI;
    step("addi_fetch", S_FETCH, cFetch(1'b1));
    step("addi_decode", S_DECODE, cDecode());
    step("addi_exec", S_EXEC_I, cExecI(ALU_ADD, 1'b0));
    step("addi_wb", S_WB_I, cWbI(ALU_ADD));

    // J
    bus1.opc = OP_J;
    step("j_fetch", S_FETCH, cFetch(1'b1));
    step("j_decode", S_DECODE, cDecode());
    step("j_jump", S_JUMP, cJump());

    // SW stalled in MEM_WR, then reset aborts it
    bus1.opc = OP_SW;
    step("sw_fetch", S_FETCH, cFetch(1'b1));
    step("sw_decode", S_DECODE, cDecode());
    step("sw_addr", S_MEM_ADDR, cMemAddr());
    bus1.memReady = 1'b0;
    step("sw_wr_wait", S_MEM_WR, cMemWr());
    rst = 1'b0;
    step("sw_rst_asserted", S_MEM_WR, cIdle());
    step("sw_rst_fetch", S_FETCH, cIdle());
    rst = 1'b1;
    step("sw_after_rst", S_FETCH, cFetch(1'b0));

    @(negedge clk);
    #1;
    total++;
    if (q1.size() + q2.size() != 0)
      $display("FAIL drain: got %0d pending, want 0", q1.size() + q2.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips32_mc_control.md
Name: mips32_mc_control

Overview:
Multi-cycle MIPS32 control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks and drives datapath enables and muxes. It replaces the single-cycle opcode/function decoder. It adds a memory ready handshake, ALU-zero-qualified branching, jumps, an immediate-ALU class and a trap state. It sits between the instruction register (opc/func) and the shared multi-cycle datapath.

Parameters:
USE_MEM_READY, 1, 1 = memory states wait for memReady; 0 = memory always completes in one cycle.
TRAP_STICKY, 1, 1 = TRAP holds until reset; 0 = TRAP lasts one cycle, then FETCH.
STATE_W, 4, width of the state debug output.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
opc  in  6  opcode from the IR (valid from DECODE onward)
func  in  6  function field from the IR
zero  in  1  ALU zero flag (registered result of the BRANCH compare)
memReady  in  1  memory access completes this cycle
pcWrite  out  1  PC load enable (includes the qualified branch)
irWrite  out  1  IR load enable
iorD  out  1  memory address: 0 = PC, 1 = ALUOut
memRead  out  1  memory read strobe
memWrite  out  1  memory write strobe
rfWriteEnable  out  1  register file write
rfWriteAddrSel  out  1  1 = rd, 0 = rt
rfWriteDataSel  out  2  0 = ALUOut, 1 = MDR
aluSrcA  out  1  0 = PC, 1 = rs
aluSrcB  out  2  0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2
aluFunc  out  3  ALU op code (shared ALU defines)
bitXtend  out  1  0 = sign extend, 1 = zero extend
pcSrc  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
isBeq  out  1  BRANCH state, BEQ
isBne  out  1  BRANCH state, BNE
invOpcode  out  1  high while in TRAP
state  out  STATE_W  current state (debug)

Behaviour:
- Reset (rst=0 at a clk edge): state = FETCH. Every strobe and enable is 0. Mux selects are 0. aluFunc = ADD.
- All outputs are combinational from the state. Exceptions: pcWrite/irWrite in FETCH (gated by memReady) and pcWrite in BRANCH (gated by zero).
- FETCH:
  - Drives memRead=1, iorD=0, aluSrcA=0, aluSrcB=1, ADD, pcSrc=0.
  - If memReady, or USE_MEM_READY=0: irWrite=1, pcWrite=1, go to DECODE. Otherwise hold FETCH with both enables 0.
- DECODE:
  - Drives aluSrcA=0, aluSrcB=3, ADD, bitXtend=0 (branch target into ALUOut).
  - Next state:
    - opc=0, func in {AND, OR, ADD, SUB, SLT} -> EXEC_R
    - LW/SW -> MEM_ADDR
    - ADDI/ANDI/ORI -> EXEC_I
    - BEQ/BNE -> BRANCH
    - J -> JUMP
    - anything else -> TRAP
- EXEC_R: aluSrcA=1, aluSrcB=0, aluFunc from func -> WB_R.
- WB_R: rfWriteEnable=1, rfWriteAddrSel=1, rfWriteDataSel=0 -> FETCH.
- EXEC_I: aluSrcA=1, aluSrcB=2, aluFunc from opc. bitXtend=1 for ANDI/ORI, 0 for ADDI -> WB_I.
- WB_I: rfWriteEnable=1, rfWriteAddrSel=0, rfWriteDataSel=0 -> FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=2, ADD, bitXtend=0. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: memRead=1, iorD=1. Waits for memReady, then MEM_WB.
- MEM_WB: rfWriteEnable=1, rfWriteAddrSel=0, rfWriteDataSel=1 -> FETCH.
- MEM_WR: memWrite=1, iorD=1. Waits for memReady, then FETCH. memWrite stays high for the whole wait.
- BRANCH:
  - aluSrcA=1, aluSrcB=0, SUB, pcSrc=1, isBeq/isBne per opc.
  - pcWrite = (isBeq & zero) | (isBne & ~zero).
  - Goes to FETCH unconditionally.
- JUMP: pcSrc=2, pcWrite=1 -> FETCH.
- TRAP: invOpcode=1, all write enables 0.
- Zero-wait latency: R-type 4, ADDI/ANDI/ORI 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles. Each memReady stall adds one cycle.
- Reset mid-instruction aborts at the next edge. No register write or memory write is issued after reset is sampled.
- opc/func are sampled only in DECODE, EXEC_R and EXEC_I. Changes on them in other states have no effect.
- Illegal state encodings -> FETCH.

Decomposition:
- Shared package/header holds:
  - state encodings;
  - aluSrcB, pcSrc and rfWriteDataSel select constants;
  - the existing MIPS opcode/function and ALU code defines, reused unchanged.
- One natural sub-module: mips32_alu_decode. It is a combinational map of opc/func to aluFunc and validity, used in DECODE/EXEC states.

Test Plan:
- AND (opc=0, func=0x24), memReady=1 -> states FETCH, DECODE, EXEC_R, WB_R. rfWriteEnable=1 only in cycle 4, with rfWriteAddrSel=1 and aluFunc=AND.
- LW with memReady low 2 cycles in MEM_RD -> memRead/iorD=1 held 3 cycles; MEM_WB write with rfWriteDataSel=1; total 7 cycles.
- BNE with zero=0 -> pcWrite=1 and pcSrc=1 in BRANCH. BNE with zero=1 -> pcWrite=0. Both return to FETCH after 3 cycles.
- ORI -> bitXtend=1 and aluSrcB=2 in EXEC_I. ADDI -> bitXtend=0.
- opc=0x3F -> TRAP, invOpcode=1, held 10 cycles (TRAP_STICKY=1). With TRAP_STICKY=0, TRAP lasts 1 cycle, then FETCH.
- SW, rst=0 asserted in MEM_WR -> next cycle state=FETCH, memWrite=0, all enables 0.
